bram2_port_sequencer: RTL and testbench
=======================================

// Module: bram2_port_sequencer
// PURPOSE
//  Request/response front end for one port of the dual-ported write-first BRAM2.
//  Accepts valid/ready read and write requests and drives the BRAM2 port pins.
//  Tracks the BRAM2 read latency (1 cycle, or 2 cycles when PIPELINED), captures DO
//  and returns read data in order through a small credit-protected response FIFO.
//  One instance sits in front of each BRAM2 port (A or B).
// PARAMETERS
//  PIPELINED   0   must match the BRAM2 instance; read latency LAT = PIPELINED ? 2 : 1
//  ADDR_WIDTH  1   BRAM2 address width
//  DATA_WIDTH  1   BRAM2 data width
//  RESP_DEPTH  4   response FIFO entries; power of 2, >= LAT+1
// PORTS
//  CLK        in   1           single clock; drives the BRAM2 CLKA/CLKB of the same port
//  RST        in   1           asynchronous, active-high reset
//  req_valid  in   1           request offered
//  req_ready  out  1           request accepted when req_valid & req_ready
//  req_write  in   1           1 = write, 0 = read
//  req_addr   in   ADDR_WIDTH  request address
//  req_data   in   DATA_WIDTH  write data; ignored for reads
//  resp_valid out  1           read data available
//  resp_ready in   1           consumer takes resp_data when resp_valid & resp_ready
//  resp_data  out  DATA_WIDTH  read data, returned in request order
//  bram_en    out  1           to BRAM2 EN
//  bram_we    out  1           to BRAM2 WE
//  bram_addr  out  ADDR_WIDTH  to BRAM2 ADDR
//  bram_di    out  DATA_WIDTH  to BRAM2 DI
//  bram_do    in   DATA_WIDTH  from BRAM2 DO
//  busy       out  1           reads in flight or FIFO not empty
// BEHAVIOUR
//  Reset values: req_ready 0, resp_valid 0, busy 0.
//  - While RST is high, bram_en is 0.
//  - All internal state clears asynchronously.
//  Credit counter outstanding = reads in flight + FIFO occupancy.
//  - Counter width is $clog2(RESP_DEPTH+1).
//  - req_ready = !RST_q & (outstanding < RESP_DEPTH).
//  - req_ready is registered-state only. It never depends on req_valid/req_write
//    or on a same-cycle pop.
//  - Writes also wait on credits; this keeps the ready rule uniform.
//  Accept cycle (fire = req_valid & req_ready):
//  - BRAM drive is combinational: bram_en = fire, bram_we = req_write,
//    bram_addr = req_addr, bram_di = req_data.
//  - When fire is 0, addr/di/we still follow the req_* inputs. This is harmless
//    because EN=0.
//  Read tracking:
//  - A read fire shifts a 1 into a LAT-deep valid shift register; any other cycle
//    shifts in 0.
//  - When bit LAT-1 is set, bram_do is pushed into the FIFO in that same cycle,
//    i.e. LAT cycles after fire.
//  - With PIPELINED=1, DO_R2 copies DO_R every cycle, so sampling exactly at
//    LAT=2 is correct even with back-to-back or gapped requests.
//  - Write fires never push; the write-first echo on DO is discarded.
//  Counter update each cycle: outstanding += read_fire - resp_pop.
//  - Simultaneous read fire and pop: outstanding is unchanged.
//  Response FIFO:
//  - First-word-fall-through: resp_valid = !empty, resp_data = head entry.
//  - Push and pop in the same cycle is legal at any occupancy, including empty
//    (the pushed word appears next cycle) and full-minus-in-flight.
//  - Overflow is impossible by construction. Checked by an assertion:
//    push while full is an error.
//  - Pointers are log2(RESP_DEPTH) bits and wrap naturally; full/empty use an
//    extra wrap bit.
//  Ordering: responses leave in read-issue order. Same-address write then read
//  gets the new data (BRAM2 write-first plus in-order issue).
//  Reset mid-operation: in-flight reads and FIFO contents are dropped; no
//  response is produced for them. After RST deasserts, req_ready rises on the
//  first CLK edge.
//  busy = (outstanding != 0).
// STRUCTURE
//  - Shared package bram_pkg: function bram_lat(PIPELINED), and a typedef for the
//    request op (RD=0, WR=1) shared with the BRAM2 arbiter.
//  - One sub-module: bram_resp_fifo (DEPTH, WIDTH; push/pop/empty/full/count,
//    async active-high reset). The credit counter and latency shift register
//    stay in the top module.
// TESTING
//  1. PIPELINED=0: write addr 3 = 0xA5, then read 3 -> resp_valid 1 cycle after
//     the read fire, resp_data 0xA5; no response for the write.
//  2. PIPELINED=1: 4 back-to-back reads of addr 0..3 preloaded 0x10..0x13 ->
//     responses 0x10,0x11,0x12,0x13 in order; first appears 2 cycles after the
//     first fire.
//  3. RESP_DEPTH=4, resp_ready=0, 6 reads offered -> exactly 4 accepted, then
//     req_ready=0. Raise resp_ready for 1 cycle -> one pop, req_ready=1 the next
//     cycle, 5th read accepted.
//  4. resp_ready=1 steady with continuous reads -> 1 response/cycle sustained;
//     outstanding stays constant under simultaneous fire+pop.
//  5. Write addr 7 = 0x3C and read addr 7 in consecutive cycles -> read
//     returns 0x3C.
//  6. Assert RST with 2 reads in flight and 2 FIFO entries -> resp_valid=0 and
//     busy=0 immediately. After release, no stale responses; a new read of a
//     known address returns correct data.

Source files
------------

// File: rtl/bram2_port_sequencer_pkg.sv
// Definitions shared by the BRAM2 port sequencers and the BRAM2 arbiter.
package bram_pkg;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } bram_op_e;

  function automatic int bram_lat(input int pipelined);
    return (pipelined != 0) ? 2 : 1;
  endfunction

endpackage

// File: rtl/bram2_port_sequencer_if.sv
// Request/response handshake bundle between a client and one BRAM2 port sequencer.
interface bram2_port_sequencer_if #(
  parameter int ADDR_WIDTH = 1,
  parameter int DATA_WIDTH = 1
) ();

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_data;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [DATA_WIDTH-1:0] resp_data;

  modport master (
    output req_valid, req_write, req_addr, req_data, resp_ready,
    input  req_ready, resp_valid, resp_data
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_data, resp_ready,
    output req_ready, resp_valid, resp_data
  );

endinterface

// File: rtl/bram2_port_sequencer_resp_fifo.sv
// First-word-fall-through response FIFO with wrap-bit pointers, plus its overflow checker.
module bram_resp_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 1,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] pop_data_o,
  output logic             empty_o,
  output logic             full_o,
  output logic [AW:0]      count_o
);

  logic [AW:0]      wr_q, wr_d;
  logic [AW:0]      rd_q, rd_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push_s;
  logic             do_pop_s;

  assign empty_o    = (wr_q == rd_q);
  assign full_o     = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign count_o    = wr_q - rd_q;
  assign pop_data_o = mem_q[rd_q[AW-1:0]];
  assign do_push_s  = push_i & ~full_o;
  assign do_pop_s   = pop_i & ~empty_o;

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (do_push_s) begin
      wr_d = wr_q + {{AW{1'b0}}, 1'b1};
    end else begin
      wr_d = wr_q;
    end
    if (do_pop_s) begin
      rd_d = rd_q + {{AW{1'b0}}, 1'b1};
    end else begin
      rd_d = rd_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_q <= {(AW+1){1'b0}};
      rd_q <= {(AW+1){1'b0}};
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // Storage carries no reset: contents are only visible through the pointers.
  always_ff @(posedge clk_i) begin
    if (do_push_s) begin
      mem_q[wr_q[AW-1:0]] <= push_data_i;
    end
  end

  bram_resp_fifo_chk u_chk (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .push_i (push_i),
    .full_i (full_o)
  );

endmodule

module bram_resp_fifo_chk (
  input logic clk_i,
  input logic rst_i,
  input logic push_i,
  input logic full_i
);

  a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i) !(push_i && full_i));

endmodule

// File: rtl/bram2_port_sequencer.sv
// Credit-protected request/response front end for one write-first BRAM2 port.
module bram2_port_sequencer
  import bram_pkg::*;
#(
  parameter int PIPELINED  = 0,
  parameter int ADDR_WIDTH = 1,
  parameter int DATA_WIDTH = 1,
  parameter int RESP_DEPTH = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  bram2_port_sequencer_if.slave port_if,
  output logic                  bram_en_o,
  output logic                  bram_we_o,
  output logic [ADDR_WIDTH-1:0] bram_addr_o,
  output logic [DATA_WIDTH-1:0] bram_di_o,
  input  logic [DATA_WIDTH-1:0] bram_do_i,
  output logic                  busy_o
);

  localparam int LAT = bram_lat(PIPELINED);
  localparam int CW  = $clog2(RESP_DEPTH + 1);
  localparam int FAW = $clog2(RESP_DEPTH);
  localparam logic [CW-1:0] CREDITS = CW'(RESP_DEPTH);
  localparam logic [CW-1:0] ONE     = CW'(1);

  logic            rst_q;
  logic [CW-1:0]   out_q, out_d;
  logic [LAT-1:0]  vld_q, vld_d;
  bram_op_e        op_s;
  logic            fire_s;
  logic            rd_fire_s;
  logic            push_s;
  logic            pop_s;
  logic            fifo_empty_s;
  logic            fifo_full_s;
  logic [FAW:0]    fifo_count_s;

  // Ready comes from registered state only so it never loops through the requester.
  assign op_s              = bram_op_e'(port_if.req_write);
  assign port_if.req_ready = ~rst_q & (out_q < CREDITS);
  assign fire_s            = port_if.req_valid & port_if.req_ready;
  assign rd_fire_s         = fire_s & (op_s == OP_RD);

  assign bram_en_o   = fire_s;
  assign bram_we_o   = port_if.req_write;
  assign bram_addr_o = port_if.req_addr;
  assign bram_di_o   = port_if.req_data;

  assign push_s             = vld_q[LAT-1];
  assign pop_s              = port_if.resp_valid & port_if.resp_ready;
  assign port_if.resp_valid = ~fifo_empty_s;
  assign busy_o             = (out_q != {CW{1'b0}});

  // Latency pipe and credit counter next state.
  always_comb begin
    vld_d    = vld_q << 1;
    vld_d[0] = rd_fire_s;
    out_d    = out_q;
    if (rd_fire_s && !pop_s) begin
      out_d = out_q + ONE;
    end else if (!rd_fire_s && pop_s) begin
      out_d = out_q - ONE;
    end else begin
      out_d = out_q;
    end
  end

  // rst_q holds ready low for the first edge after reset release.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rst_q <= 1'b1;
      out_q <= {CW{1'b0}};
      vld_q <= {LAT{1'b0}};
    end else begin
      rst_q <= 1'b0;
      out_q <= out_d;
      vld_q <= vld_d;
    end
  end

  bram_resp_fifo #(
    .DEPTH (RESP_DEPTH),
    .WIDTH (DATA_WIDTH)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (push_s),
    .push_data_i (bram_do_i),
    .pop_i       (pop_s),
    .pop_data_o  (port_if.resp_data),
    .empty_o     (fifo_empty_s),
    .full_o      (fifo_full_s),
    .count_o     (fifo_count_s)
  );

  bram2_port_sequencer_chk #(
    .CW  (CW),
    .FW  (FAW + 1)
  ) u_chk (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .outstanding_i(out_q),
    .credits_i    (CREDITS),
    .fifo_count_i (fifo_count_s),
    .fifo_full_i  (fifo_full_s)
  );

endmodule

module bram2_port_sequencer_chk #(
  parameter int CW = 1,
  parameter int FW = 1
) (
  input logic          clk_i,
  input logic          rst_i,
  input logic [CW-1:0] outstanding_i,
  input logic [CW-1:0] credits_i,
  input logic [FW-1:0] fifo_count_i,
  input logic          fifo_full_i
);

  a_count_le_credits: assert property (@(posedge clk_i) disable iff (rst_i)
    int'(fifo_count_i) <= int'(outstanding_i));
  a_full_no_inflight: assert property (@(posedge clk_i) disable iff (rst_i)
    fifo_full_i |-> (outstanding_i == credits_i));

endmodule

// File: tb/tb_bram2_port_sequencer.sv
// Directed bench: one non-pipelined and one pipelined sequencer, each with a write-first BRAM2 model.
module tb_bram2_port_sequencer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       rv [2], rw [2], rr [2];
  logic [3:0] ra [2], addr [2];
  logic [7:0] rd [2], vd [2], di [2], bdo [2];
  logic       rdy [2], vv [2], en [2], we [2], busy [2];

  int n_cmp = 0;
  int n_bad = 0;

  bram2_port_sequencer_if #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) if0 ();
  bram2_port_sequencer_if #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) if1 ();

  assign if0.req_valid  = rv[0];
  assign if0.req_write  = rw[0];
  assign if0.req_addr   = ra[0];
  assign if0.req_data   = rd[0];
  assign if0.resp_ready = rr[0];
  assign rdy[0]         = if0.req_ready;
  assign vv[0]          = if0.resp_valid;
  assign vd[0]          = if0.resp_data;
  assign if1.req_valid  = rv[1];
  assign if1.req_write  = rw[1];
  assign if1.req_addr   = ra[1];
  assign if1.req_data   = rd[1];
  assign if1.resp_ready = rr[1];
  assign rdy[1]         = if1.req_ready;
  assign vv[1]          = if1.resp_valid;
  assign vd[1]          = if1.resp_data;

  bram2_port_sequencer #(.PIPELINED(0), .ADDR_WIDTH(4), .DATA_WIDTH(8), .RESP_DEPTH(4)) u_dut0 (
    .clk_i(clk), .rst_i(rst), .port_if(if0),
    .bram_en_o(en[0]), .bram_we_o(we[0]), .bram_addr_o(addr[0]), .bram_di_o(di[0]),
    .bram_do_i(bdo[0]), .busy_o(busy[0])
  );

  bram2_port_sequencer #(.PIPELINED(1), .ADDR_WIDTH(4), .DATA_WIDTH(8), .RESP_DEPTH(4)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .port_if(if1),
    .bram_en_o(en[1]), .bram_we_o(we[1]), .bram_addr_o(addr[1]), .bram_di_o(di[1]),
    .bram_do_i(bdo[1]), .busy_o(busy[1])
  );

  // Write-first BRAM2 port model; instance 1 adds the DO_R2 output register.
  for (genvar k = 0; k < 2; k++) begin : g_bram
    logic [7:0] mem [16];
    logic [7:0] do_r, do_r2;
    initial begin
      for (int i = 0; i < 16; i++) mem[i] = 8'h00;
      if (k == 0) begin
        mem[7] = 8'h77;
        for (int i = 8; i < 14; i++) mem[i] = 8'(8'h80 + i - 8);
      end else begin
        for (int i = 0; i < 4; i++) mem[i] = 8'(8'h10 + i);
      end
    end
    always @(posedge clk) begin
      if (en[k]) begin
        if (we[k]) begin
          mem[addr[k]] <= di[k];
          do_r         <= di[k];
        end else begin
          do_r <= mem[addr[k]];
        end
      end
      do_r2 <= do_r;
    end
    assign bdo[k] = (k == 1) ? do_r2 : do_r;
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      rv[k] = 1'b0; rw[k] = 1'b0; rr[k] = 1'b0; ra[k] = 4'h0; rd[k] = 8'h00;
    end
    rv[0] = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_ready0", 32'(rdy[0]), 32'd0);
    check_eq("rst_ready1", 32'(rdy[1]), 32'd0);
    check_eq("rst_valid0", 32'(vv[0]), 32'd0);
    check_eq("rst_busy0", 32'(busy[0]), 32'd0);
    check_eq("rst_en0", 32'(en[0]), 32'd0);
    rst = 1'b0;
    rv[0] = 1'b0;
    tick(); #2;
    check_eq("rel_ready0", 32'(rdy[0]), 32'd1);

    // 1: write 3=A5 then read 3, non-pipelined
    rv[0] = 1'b1; rw[0] = 1'b1; ra[0] = 4'd3; rd[0] = 8'hA5;
    #2;
    check_eq("t1_en", 32'(en[0]), 32'd1);
    check_eq("t1_we", 32'(we[0]), 32'd1);
    check_eq("t1_addr", 32'(addr[0]), 32'd3);
    check_eq("t1_di", 32'(di[0]), 32'hA5);
    tick(); rw[0] = 1'b0; #2;
    check_eq("t1_rd_we", 32'(we[0]), 32'd0);
    check_eq("t1_nowr_resp", 32'(vv[0]), 32'd0);
    tick(); rv[0] = 1'b0; #2;
    check_eq("t1_not_yet", 32'(vv[0]), 32'd0);
    check_eq("t1_busy", 32'(busy[0]), 32'd1);
    tick(); #2;
    check_eq("t1_valid", 32'(vv[0]), 32'd1);
    check_eq("t1_data", 32'(vd[0]), 32'hA5);
    rr[0] = 1'b1;
    tick(); rr[0] = 1'b0; #2;
    check_eq("t1_drained", 32'(vv[0]), 32'd0);
    check_eq("t1_idle", 32'(busy[0]), 32'd0);

    // 2: pipelined, 4 back-to-back reads of 0..3
    rr[1] = 1'b1; rv[1] = 1'b1; rw[1] = 1'b0; ra[1] = 4'd0;
    tick(); ra[1] = 4'd1; #2;
    check_eq("t2_lat1", 32'(vv[1]), 32'd0);
    tick(); ra[1] = 4'd2; #2;
    check_eq("t2_lat2", 32'(vv[1]), 32'd0);
    tick(); ra[1] = 4'd3; #2;
    check_eq("t2_valid", 32'(vv[1]), 32'd1);
    check_eq("t2_d0", 32'(vd[1]), 32'h10);
    tick(); rv[1] = 1'b0; #2;
    check_eq("t2_d1", 32'(vd[1]), 32'h11);
    check_eq("t2_ready", 32'(rdy[1]), 32'd1);
    tick(); #2;
    check_eq("t2_d2", 32'(vd[1]), 32'h12);
    tick(); #2;
    check_eq("t2_d3", 32'(vd[1]), 32'h13);
    tick(); #2;
    check_eq("t2_empty", 32'(vv[1]), 32'd0);
    check_eq("t2_idle", 32'(busy[1]), 32'd0);

    // 3: credit exhaustion with resp_ready low
    rr[0] = 1'b0; rv[0] = 1'b1; rw[0] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ra[0] = 4'(8 + i);
      #2;
      check_eq("t3_ready", 32'(rdy[0]), 32'd1);
      tick();
    end
    ra[0] = 4'd12;
    #2;
    check_eq("t3_full", 32'(rdy[0]), 32'd0);
    check_eq("t3_head", 32'(vd[0]), 32'h80);
    tick(); #2;
    check_eq("t3_still_full", 32'(rdy[0]), 32'd0);
    rr[0] = 1'b1;
    tick(); rr[0] = 1'b0; #2;
    check_eq("t3_reopen", 32'(rdy[0]), 32'd1);
    check_eq("t3_head2", 32'(vd[0]), 32'h81);
    tick(); #2;
    check_eq("t3_refull", 32'(rdy[0]), 32'd0);
    rv[0] = 1'b0; rr[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(); #2;
      check_eq("t3_drain", 32'(vd[0]), 32'(8'h82 + i));
    end
    tick(); #2;
    check_eq("t3_empty", 32'(vv[0]), 32'd0);

    // 4: sustained throughput with simultaneous fire and pop
    rv[0] = 1'b1; rw[0] = 1'b0;
    for (int i = 0; i < 6; i++) begin
      ra[0] = 4'(8 + i);
      tick(); #2;
      check_eq("t4_ready", 32'(rdy[0]), 32'd1);
      if (i >= 1) begin
        check_eq("t4_valid", 32'(vv[0]), 32'd1);
        check_eq("t4_data", 32'(vd[0]), 32'(8'h80 + i - 1));
      end
    end
    rv[0] = 1'b0;
    tick(); #2;
    check_eq("t4_last", 32'(vd[0]), 32'h85);
    tick(); #2;
    check_eq("t4_empty", 32'(vv[0]), 32'd0);
    check_eq("t4_idle", 32'(busy[0]), 32'd0);

    // 5: write 7=3C then read 7 next cycle
    rv[0] = 1'b1; rw[0] = 1'b1; ra[0] = 4'd7; rd[0] = 8'h3C;
    tick(); rw[0] = 1'b0;
    tick(); rv[0] = 1'b0;
    tick(); #2;
    check_eq("t5_valid", 32'(vv[0]), 32'd1);
    check_eq("t5_data", 32'(vd[0]), 32'h3C);
    tick(); #2;
    check_eq("t5_empty", 32'(vv[0]), 32'd0);

    // 6: reset with 2 reads in flight and 2 FIFO entries
    rr[1] = 1'b0; rv[1] = 1'b1; rw[1] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ra[1] = 4'(i);
      tick();
    end
    #1;
    check_eq("t6_pre_valid", 32'(vv[1]), 32'd1);
    check_eq("t6_pre_busy", 32'(busy[1]), 32'd1);
    rst = 1'b1;
    #1;
    check_eq("t6_rst_valid", 32'(vv[1]), 32'd0);
    check_eq("t6_rst_busy", 32'(busy[1]), 32'd0);
    check_eq("t6_rst_en", 32'(en[1]), 32'd0);
    tick(); tick();
    rst = 1'b0; rv[1] = 1'b0;
    tick(); #2;
    check_eq("t6_ready", 32'(rdy[1]), 32'd1);
    for (int i = 0; i < 4; i++) begin
      tick(); #2;
      check_eq("t6_no_stale", 32'(vv[1]), 32'd0);
    end
    rv[1] = 1'b1; ra[1] = 4'd2;
    tick(); rv[1] = 1'b0;
    tick(); #2;
    check_eq("t6_lat", 32'(vv[1]), 32'd0);
    tick(); #2;
    check_eq("t6_valid", 32'(vv[1]), 32'd1);
    check_eq("t6_data", 32'(vd[1]), 32'h12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
